// File: rtl/seq_uart_tx_pkg.sv
// Shared sequencer/UART definitions: datapath width, UART defaults and state encoding.
package seq_uart_tx_pkg;

  localparam int seq_dp_width   = 8;
  localparam int UART_CLK_DIV   = 868;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/seq_uart_baud.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and flags the final cycle of each bit.
module seq_uart_baud
  import seq_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] NEXT_LAST = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // pre_tick lets a consumer register an output that must line up with tick
  assign tick     = enable && (cnt == LAST);
  assign pre_tick = enable && (cnt == NEXT_LAST);

endmodule

// File: rtl/seq_uart_tx.sv
// UART transmitter for the sequencer send interface: start bit, LSB-first data, stop bit(s).
module seq_uart_tx
  import seq_uart_tx_pkg::*;
#(
  parameter int DATA_W    = seq_dp_width,
  parameter int CLK_DIV   = UART_CLK_DIV,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_busy,
  output logic              o_txd,
  output logic              o_tx_done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t       state;
  logic [DATA_W-1:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              accept;
  logic              tick;
  logic              pre_tick;

  assign accept = (state == IDLE) && i_tx_valid;

  seq_uart_baud #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (state != IDLE),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Outputs are loaded one edge ahead of the bit they describe, so the line never glitches
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      o_txd     <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_tx_valid) begin
            shift_reg <= i_tx_data;
            state     <= START;
            o_txd     <= 1'b0;
            o_tx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            o_txd <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
              o_txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_txd   <= shift_reg[1];
            end
          end
        end
        STOP: begin
          // done must land in the final cycle, so it is armed one cycle early
          if (pre_tick && (stop_cnt == STOP_LAST)) begin
            o_tx_done <= 1'b1;
          end
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              stop_cnt  <= 1'b0;
              state     <= IDLE;
              o_tx_busy <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_uart_tx.sv
// Bench for seq_uart_tx: two configurations share one stimulus stream, each checked
// every cycle against a frame-arithmetic model, plus hand-computed spot checks.
module tb_seq_uart_tx;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       txd_a, busy_a, done_a;
  logic       txd_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seq_uart_tx #(.DATA_W(8), .CLK_DIV(4), .STOP_BITS(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_busy  (busy_a),
    .o_txd      (txd_a),
    .o_tx_done  (done_a)
  );

  seq_uart_tx #(.DATA_W(8), .CLK_DIV(2), .STOP_BITS(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_busy  (busy_b),
    .o_txd      (txd_b),
    .o_tx_done  (done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    tx_valid = v;
    tx_data  = d;
    rst      = r;
  endtask

  // {busy, txd, done} in cycle c for a frame accepted in cycle k
  function automatic logic [2:0] model_out(input int cd, input int sb, input bit act,
                                           input int k, input logic [7:0] b, input int c);
    int off, f, slot;
    logic line;
    f   = (9 + sb) * cd;
    off = c - k;
    if (!act || off < 1 || off > f) return 3'b010;
    slot = (off - 1) / cd;
    if (slot == 0)      line = 1'b0;
    else if (slot <= 8) line = b[slot-1];
    else                line = 1'b1;
    return {1'b1, line, (off == f)};
  endfunction

  initial begin : model_check
    int cd[2];
    int sb[2];
    bit act[2];
    int mk[2];
    logic [7:0] mb[2];
    logic r, v;
    logic [7:0] d;
    int e;
    logic [2:0] exp_o, got;
    cd[0] = 4; cd[1] = 2;
    sb[0] = 1; sb[1] = 2;
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; mk[m] = 0; mb[m] = 8'h00;
    end
    forever begin
      @(posedge clk);
      r = rst; v = tx_valid; d = tx_data; e = cyc;
      #1;
      cyc = e + 1;
      for (int m = 0; m < 2; m++) begin
        if (!r) act[m] = 0;
        else if (v && !(act[m] && (e - mk[m]) >= 1 && (e - mk[m]) <= (9 + sb[m]) * cd[m])) begin
          act[m] = 1; mk[m] = e; mb[m] = d;
        end
        exp_o = model_out(cd[m], sb[m], act[m], mk[m], mb[m], cyc);
        got   = (m == 0) ? {busy_a, txd_a, done_a} : {busy_b, txd_b, done_b};
        checkOutput($sformatf("dut%0d_busy", m), 32'(got[2]), 32'(exp_o[2]));
        checkOutput($sformatf("dut%0d_txd", m),  32'(got[1]), 32'(exp_o[1]));
        checkOutput($sformatf("dut%0d_done", m), 32'(got[0]), 32'(exp_o[0]));
      end
    end
  end

  initial begin : stimulus
    int k;
    int ndone;
    int ones;
    logic [9:0] pat;
    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    pat = '0;

    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("idle_txd", 32'(txd_a), 32'd1);
    checkOutput("idle_busy", 32'(busy_a), 32'd0);

    // single frame 0xA5
    applyStimulus(1'b1, 8'hA5, 1'b1);
    k = cyc;
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (i <= 40 && ((i - 1) % 4) == 0) pat[(i-1)/4] = txd_a;
      if (i == 39) checkOutput("a5_done_early", 32'(done_a), 32'd0);
      if (i == 40) begin
        checkOutput("a5_done_last", 32'(done_a), 32'd1);
        checkOutput("a5_busy_last", 32'(busy_a), 32'd1);
      end
      if (i == 41) checkOutput("a5_busy_after", 32'(busy_a), 32'd0);
    end
    checkOutput("a5_slots", 32'(pat), 32'(10'b1101001010));

    // request while busy is dropped
    applyStimulus(1'b1, 8'h3C, 1'b1);
    ndone = 0;
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(i == 10, (i == 10) ? 8'hFF : 8'h00, 1'b1);
      if (done_a) ndone++;
      if (i == 41) checkOutput("3c_busy_after", 32'(busy_a), 32'd0);
    end
    checkOutput("3c_done_count", 32'(ndone), 32'd1);

    // back-to-back frames, second request in the first idle cycle
    applyStimulus(1'b1, 8'h00, 1'b1);
    for (int i = 1; i <= 85; i++) begin
      applyStimulus(i == 41, (i == 41) ? 8'hFF : 8'h00, 1'b1);
      if (i == 40) checkOutput("b2b_stop", 32'(txd_a), 32'd1);
      if (i == 41) checkOutput("b2b_gap", 32'(txd_a), 32'd1);
      if (i == 42) checkOutput("b2b_start2", 32'(txd_a), 32'd0);
      if (i == 81) checkOutput("b2b_done2", 32'(done_a), 32'd1);
    end

    // reset mid-frame, then a clean frame
    applyStimulus(1'b1, 8'h81, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 8'h00, i != 15);
      if (i == 16) begin
        checkOutput("abort_txd", 32'(txd_a), 32'd1);
        checkOutput("abort_busy", 32'(busy_a), 32'd0);
      end
    end
    applyStimulus(1'b1, 8'h55, 1'b1);
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (i == 1) checkOutput("post_abort_start", 32'(txd_a), 32'd0);
      if (i == 40) checkOutput("post_abort_done", 32'(done_a), 32'd1);
    end

    // two stop bits at CLK_DIV=2 on the second instance
    applyStimulus(1'b1, 8'h0F, 1'b1);
    ones = 0;
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (i == 18) checkOutput("sb2_bit7", 32'(txd_b), 32'd0);
      if (i >= 19 && i <= 22 && txd_b) ones++;
      if (i == 21) checkOutput("sb2_done_early", 32'(done_b), 32'd0);
      if (i == 22) checkOutput("sb2_done", 32'(done_b), 32'd1);
      if (i == 23) checkOutput("sb2_busy_after", 32'(busy_b), 32'd0);
    end
    checkOutput("sb2_stop_ones", 32'(ones), 32'd4);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 99) != 0);
    end
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
